// File: rtl/hc165_defs.sv
// Shared definitions for the 74HC165 reader: FSM state encodings and default sizing.
package hc165_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOW    = 3'd3,
    ST_HIGH   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/hc165_tick_div.sv
// Free-running clock divider with enable and synchronous clear; tick marks the last count.
module hc165_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clr) begin
      div <= '0;
    end else if (en) begin
      div <= (div == LAST) ? '0 : div + CW'(1);
    end
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/hc165_reader.sv
// Scans a chain of 74HC165 devices: parallel load, settle, then DATA_W CP pulses
// sampling Q7 through a 2-flop synchronizer; the completed word is strobed on dat_vld.
module hc165_reader
  import hc165_defs::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int AUTO    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              Q7,
  output logic              PL_n,
  output logic              CP,
  output logic              CE_n,
  output logic              busy,
  output logic [DATA_W-1:0] dat_out,
  output logic              dat_vld
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              q7_meta;
  logic              q7_s;
  logic              go;
  logic              div_en;
  logic              div_clr;
  logic              tick;

  // Q7 is driven by the external chain and has no timing relation to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q7_meta <= 1'b0;
      q7_s    <= 1'b0;
    end else begin
      q7_meta <= Q7;
      q7_s    <= q7_meta;
    end
  end

  assign go      = (AUTO != 0) ? 1'b1 : start;
  assign div_en  = (state != ST_IDLE) && (state != ST_DONE);
  assign div_clr = (state == ST_IDLE) && go;

  hc165_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      PL_n    <= 1'b1;
      CP      <= 1'b0;
      CE_n    <= 1'b1;
      busy    <= 1'b0;
      dat_out <= '0;
      dat_vld <= 1'b0;
    end else begin
      dat_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          PL_n <= 1'b1;
          CP   <= 1'b0;
          CE_n <= 1'b1;
          busy <= 1'b0;
          if (go) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
            PL_n    <= 1'b0;
            CE_n    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (tick) begin
            state <= ST_SETTLE;
            PL_n  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            state <= ST_LOW;
          end
        end
        ST_LOW: begin
          // Sample just before raising CP, while Q7 has had a full half-period to settle.
          if (tick) begin
            shift <= {shift[DATA_W-2:0], q7_s};
            state <= ST_HIGH;
            CP    <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            CP <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= ST_DONE;
              dat_out <= shift;
              dat_vld <= 1'b1;
              CE_n    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              state   <= ST_LOW;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          CP    <= 1'b0;
          CE_n  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc165_reader.sv
// Scoreboard bench for hc165_reader: 8-bit, 16-bit (two chained devices) and AUTO instances
// each driven by a behavioural 74HC165 chain model.
module tb_hc165_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] data;
    longint      due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // ---------------- DUT 0: 8-bit, start-triggered ----------------
  logic       rst_n8 = 1'b0, start8 = 1'b0, q7_8, pl_n8, cp8, ce_n8, busy8, vld8;
  logic [7:0] dout8, par8 = '0, sr8 = '0;
  logic       cp8_d = 1'b0;

  hc165_reader #(.DATA_W(8), .CLK_DIV(4), .AUTO(0)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .Q7(q7_8), .PL_n(pl_n8), .CP(cp8),
    .CE_n(ce_n8), .busy(busy8), .dat_out(dout8), .dat_vld(vld8)
  );

  always @(posedge clk) begin
    if (!pl_n8) sr8 <= par8;
    else if (cp8 && !cp8_d && !ce_n8) sr8 <= {sr8[6:0], 1'b0};
    cp8_d <= cp8;
  end
  assign q7_8 = sr8[7];

  // ---------------- DUT 1: 16-bit, two chained devices ----------------
  logic        rst_n16 = 1'b0, start16 = 1'b0, q7_16, pl_n16, cp16, ce_n16, busy16, vld16;
  logic [15:0] dout16, par16 = '0, sr16 = '0;
  logic        cp16_d = 1'b0;

  hc165_reader #(.DATA_W(16), .CLK_DIV(4), .AUTO(0)) dut16 (
    .clk(clk), .rst_n(rst_n16), .start(start16), .Q7(q7_16), .PL_n(pl_n16), .CP(cp16),
    .CE_n(ce_n16), .busy(busy16), .dat_out(dout16), .dat_vld(vld16)
  );

  always @(posedge clk) begin
    if (!pl_n16) sr16 <= par16;
    else if (cp16 && !cp16_d && !ce_n16) sr16 <= {sr16[14:0], 1'b0};
    cp16_d <= cp16;
  end
  assign q7_16 = sr16[15];

  // ---------------- DUT 2: 8-bit, AUTO rescan ----------------
  logic       rst_na = 1'b0, start_a = 1'b0, q7_a, pl_na, cpa, ce_na, busya, vlda;
  logic [7:0] douta, para = '0, sra = '0;
  logic       cpa_d = 1'b0;

  hc165_reader #(.DATA_W(8), .CLK_DIV(4), .AUTO(1)) dut_auto (
    .clk(clk), .rst_n(rst_na), .start(start_a), .Q7(q7_a), .PL_n(pl_na), .CP(cpa),
    .CE_n(ce_na), .busy(busya), .dat_out(douta), .dat_vld(vlda)
  );

  always @(posedge clk) begin
    if (!pl_na) sra <= para;
    else if (cpa && !cpa_d && !ce_na) sra <= {sra[6:0], 1'b0};
    cpa_d <= cpa;
  end
  assign q7_a = sra[7];

  // ---------------- checking ----------------
  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sb_size(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_push(input int id, input logic [15:0] data, input longint due);
    exp_t e;
    e.data = data;
    e.due  = due;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int id, output exp_t e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  int   pl_cnt[3];
  int   cp_cnt[3];
  logic cp_prev[3];
  logic busy_pending[3];

  task automatic observe(input int id, input int w, input logic rstn, input logic vld,
                         input logic busy, input logic pl_n, input logic cp,
                         input logic [15:0] dout);
    exp_t e;
    if (!rstn) begin
      pl_cnt[id] = 0;
      cp_cnt[id] = 0;
      cp_prev[id] = 1'b0;
      busy_pending[id] = 1'b0;
      return;
    end
    if (busy_pending[id]) begin
      check_value($sformatf("dut%0d busy_after_vld", id), 32'(busy), 32'd0);
      busy_pending[id] = 1'b0;
    end
    if (!pl_n) pl_cnt[id]++;
    if (cp && !cp_prev[id]) cp_cnt[id]++;
    cp_prev[id] = cp;
    if (vld) begin
      if (sb_size(id) == 0) begin
        check_value($sformatf("dut%0d unexpected_vld", id), 32'd1, 32'd0);
      end else begin
        sb_pop(id, e);
        $display("dut%0d scan: dat_out=0x%0h expected 0x%0h at cycle %0d (due %0d)",
                 id, dout, e.data, cyc, e.due);
        check_value($sformatf("dut%0d dat_out", id), 32'(dout), 32'(e.data));
        check_value($sformatf("dut%0d vld_cycle", id), 32'(cyc), 32'(e.due));
        check_value($sformatf("dut%0d cp_rises", id), 32'(cp_cnt[id]), 32'(w));
        check_value($sformatf("dut%0d pl_low_clks", id), 32'(pl_cnt[id]), 32'd4);
      end
      pl_cnt[id] = 0;
      cp_cnt[id] = 0;
      busy_pending[id] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    observe(0, 8,  rst_n8,  vld8,  busy8,  pl_n8,  cp8,  {8'h00, dout8});
    observe(1, 16, rst_n16, vld16, busy16, pl_n16, cp16, dout16);
    observe(2, 8,  rst_na,  vlda,  busya,  pl_na,  cpa,  {8'h00, douta});
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input int id, input logic [15:0] data);
    @(negedge clk);
    if (id == 0) begin
      start8 = 1'b1;
      sb_push(0, data, cyc + 1 + 72);
    end else begin
      start16 = 1'b1;
      sb_push(1, data, cyc + 1 + 136);
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_drain(input int id, input int budget);
    int n = 0;
    while (sb_size(id) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value($sformatf("dut%0d drain", id), 32'(sb_size(id)), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cp8(input int n, input int budget);
    int k = 0;
    while (cp_cnt[0] < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_value("dut0 cp_wait", 32'(cp_cnt[0] >= n), 32'd1);
  endtask

  task automatic wait_vld_auto(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      start_a = 1'($urandom_range(0, 1));
      k++;
    end while (!vlda && k < budget);
    check_value("dut2 vld_wait", 32'(vlda), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    longint due0;
    for (int i = 0; i < 3; i++) begin
      pl_cnt[i] = 0; cp_cnt[i] = 0; cp_prev[i] = 1'b0; busy_pending[i] = 1'b0;
    end

    // 1: reset with random inputs, then a long idle stretch
    repeat (6) begin
      @(negedge clk);
      start8  = 1'($urandom_range(0, 1));
      start16 = 1'($urandom_range(0, 1));
      start_a = 1'($urandom_range(0, 1));
      par8    = 8'($urandom);
      par16   = 16'($urandom);
    end
    check_value("rst PL_n", 32'(pl_n8), 32'd1);
    check_value("rst CP", 32'(cp8), 32'd0);
    check_value("rst CE_n", 32'(ce_n8), 32'd1);
    check_value("rst busy", 32'(busy8), 32'd0);
    check_value("rst dat_vld", 32'(vld8), 32'd0);
    check_value("rst dat_out", 32'(dout8), 32'd0);
    check_value("rst16 dat_out", 32'(dout16), 32'd0);
    check_value("rst16 PL_n", 32'(pl_n16), 32'd1);
    start8 = 1'b0;
    start16 = 1'b0;
    rst_n8 = 1'b1;
    rst_n16 = 1'b1;
    repeat (200) @(negedge clk);
    check_value("idle PL_n", 32'(pl_n8), 32'd1);
    check_value("idle CE_n", 32'(ce_n8), 32'd1);
    check_value("idle busy", 32'(busy8), 32'd0);
    check_value("idle dat_out", 32'(dout8), 32'd0);
    check_value("idle16 busy", 32'(busy16), 32'd0);

    // 2: single device holding 0xA5
    par8 = 8'hA5;
    pulse_start(0, 16'h00A5);
    wait_drain(0, 300);

    // 3: two chained devices holding 0x3C81
    par16 = 16'h3C81;
    pulse_start(1, 16'h3C81);
    wait_drain(1, 400);

    // 4: inputs change after load, start re-pulsed mid-scan
    par8 = 8'hA5;
    pulse_start(0, 16'h00A5);
    begin
      int k = 0;
      while (!(pl_cnt[0] > 0 && pl_n8) && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    par8 = 8'h5A;
    wait_cp8(4, 100);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_drain(0, 300);
    check_value("no_queue busy", 32'(busy8), 32'd0);
    pulse_start(0, 16'h005A);
    wait_drain(0, 300);

    // 5: asynchronous reset during HIGH of bit 4
    par8 = 8'h3C;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_cp8(5, 100);
    #2 rst_n8 = 1'b0;
    #1;
    check_value("midrst PL_n", 32'(pl_n8), 32'd1);
    check_value("midrst CP", 32'(cp8), 32'd0);
    check_value("midrst CE_n", 32'(ce_n8), 32'd1);
    check_value("midrst busy", 32'(busy8), 32'd0);
    check_value("midrst dat_out", 32'(dout8), 32'd0);
    repeat (3) @(negedge clk);
    rst_n8 = 1'b1;
    repeat (100) @(negedge clk);
    check_value("post_rst dat_out", 32'(dout8), 32'd0);
    par8 = 8'hF0;
    pulse_start(0, 16'h00F0);
    wait_drain(0, 300);

    // 6: AUTO rescans 74 clocks apart, start ignored
    para = 8'h01;
    @(negedge clk);
    due0 = cyc + 1 + 72;
    sb_push(2, 16'h0001, due0);
    sb_push(2, 16'h0002, due0 + 74);
    sb_push(2, 16'h0003, due0 + 148);
    rst_na = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      wait_vld_auto(200);
      para = 8'(k);
    end
    @(negedge clk);
    rst_na = 1'b0;
    check_value("dut2 drain", 32'(q2.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hc165_reader.md
Name: hc165_reader

Overview:
- Driver for one or more daisy-chained 74HC165 parallel-in/serial-out shift registers. It is the input-side counterpart of the HC595 output driver.
- Pulses PL_n to latch the parallel inputs, then clocks DATA_W bits out of Q7 with CP.
- Presents the captured word on dat_out with a one-cycle dat_vld strobe.
- Sits between board-level switch/key banks and the key-scan/debounce logic.

Parameters:
- DATA_W, 8: bits per scan, 8 × number of chained devices; must be ≥ 2.
- CLK_DIV, 4: clk cycles per CP half-period; must be ≥ 4 so the 2-flop Q7 synchronizer settles within a half-period.
- AUTO, 0: 1 = rescan continuously and ignore start; 0 = scan only on a start request.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: scan request, sampled only in IDLE.
- Q7  in  1: serial data from the last 74HC165 in the chain; asynchronous to clk.
- PL_n  out  1: parallel load, active low.
- CP  out  1: shift clock; the device shifts on the rising edge.
- CE_n  out  1: clock enable, active low.
- busy  out  1: high while a scan is in progress.
- dat_out  out  DATA_W: last completed scan, MSB = first bit shifted out.
- dat_vld  out  1: one-cycle strobe, high the cycle dat_out updates.

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values, applied immediately: PL_n=1, CP=0, CE_n=1, busy=0, dat_out=0, dat_vld=0, state=IDLE, divider=0, bit_cnt=0, shift register=0, synchronizer flops=0.
- Q7 passes through a 2-flop synchronizer (q7_s) before use.
- Divider: counts 0..CLK_DIV-1 while the state is not IDLE or DONE. tick = (div==CLK_DIV-1). The divider clears on entry to LOAD.
- FSM (registered outputs):
  - IDLE: PL_n=1, CP=0, CE_n=1, busy=0. Goes to LOAD when start=1, or unconditionally when AUTO=1.
  - LOAD: PL_n=0, CE_n=0, busy=1, lasts CLK_DIV clocks; on tick goes to SETTLE.
  - SETTLE: PL_n=1, CP=0, lasts CLK_DIV clocks so the first bit is valid on Q7; on tick goes to LOW.
  - LOW: CP=0; on tick: shift <= {shift[DATA_W-2:0], q7_s}, then go to HIGH.
  - HIGH: CP=1; on tick: if bit_cnt==DATA_W-1, clear bit_cnt and go to DONE; else bit_cnt++ and go to LOW.
  - DONE (1 clock): dat_out <= shift, dat_vld=1, busy=1, CP=0, CE_n=1; then go to IDLE.
- Totals: exactly DATA_W CP rising edges per scan; PL_n is low exactly CLK_DIV clocks per scan.
- Latency: with the start-sampling edge as edge 0, dat_vld is high in the cycle after edge 2·CLK_DIV·(DATA_W+1). With defaults that is edge 72.
- AUTO=1 period: 2·CLK_DIV·(DATA_W+1)+2 clocks (74 with defaults).
- start while busy (any state other than IDLE) is ignored; there is no queueing.
- dat_out holds its value between scans and changes only in DONE.
- Reset mid-scan: the partial word is discarded, no dat_vld is issued, and all outputs return to their reset values immediately.
- Parallel inputs changing after PL_n rises must not affect the result.
- bit_cnt width: $clog2(DATA_W).

Decomposition:
- Shared include/package hc165_defs:
  - state encodings ST_IDLE, ST_LOAD, ST_SETTLE, ST_LOW, ST_HIGH, ST_DONE (3-bit);
  - default constants for DATA_W and CLK_DIV.
- One natural sub-module, hc165_tick_div: parameterised CLK_DIV divider with enable/clear, outputs tick. Reusable by the HC595 path.
- Synchronizer and FSM stay in hc165_reader.

Test Plan:
1. Assert rst_n=0 with random inputs → PL_n=1, CP=0, CE_n=1, busy=0, dat_vld=0, dat_out=0. After release with start=0 for 200 clocks, outputs are unchanged.
2. Chain model of 1 device loaded with 8'hA5, start pulsed 1 clock → PL_n low 4 clocks, 8 CP rising edges, dat_vld high for exactly 1 cycle at edge 72, dat_out=8'hA5, busy falls the following cycle.
3. DATA_W=16, model of 2 chained devices holding 16'h3C81 → 16 CP rising edges, dat_out=16'h3C81, dat_vld at edge 136.
4. Model parallel inputs changed 8'hA5→8'h5A after PL_n rises, with start re-pulsed at bit 3 → single dat_vld, dat_out=8'hA5. A second scan then returns 8'h5A.
5. rst_n pulsed low during HIGH of bit 4 → immediate reset values, no dat_vld. Next start with 8'hF0 loaded → dat_out=8'hF0.
6. AUTO=1, model inputs stepping 8'h01, 8'h02, 8'h03 → dat_vld strobes exactly 74 clocks apart carrying 8'h01, 8'h02, 8'h03 in order; start is ignored throughout.
